// File: rtl/seq_divider.sv
// Iterative radix-2 restoring divider for RV32M DIV/DIVU/REM/REMU.
// Works on operand magnitudes for N cycles, then applies sign and divide-by-zero fixes in one cycle.
module seq_divider #(
  parameter int N = 32
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  logic         is_signed,
  input  logic [N-1:0] dividend,
  input  logic [N-1:0] divisor,
  output logic         busy,
  output logic         done,
  output logic [N-1:0] quotient,
  output logic [N-1:0] remainder
);

  localparam int CW = $clog2(N);

  typedef enum logic [1:0] {IDLE, CALC, FIX} state_t;

  state_t         state_q, state_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic [N-1:0]   rem_q, rem_d;
  logic [N-1:0]   quo_q, quo_d;
  logic [N-1:0]   dvsr_q, dvsr_d;
  logic [N-1:0]   dvnd_q, dvnd_d;
  logic           neg_quo_q, neg_quo_d;
  logic           neg_rem_q, neg_rem_d;
  logic           dz_q, dz_d;
  logic [N-1:0]   quotient_q, quotient_d;
  logic [N-1:0]   remainder_q, remainder_d;
  logic           done_q, done_d;

  logic [N:0]     shifted;
  logic [N:0]     diff;

  // Magnitude in N bits; the most negative value maps onto itself read as unsigned.
  function automatic logic [N-1:0] mag(input logic [N-1:0] x, input logic sgn);
    mag = (sgn && x[N-1]) ? (~x + 1'b1) : x;
  endfunction

  function automatic logic [N-1:0] cond_neg(input logic [N-1:0] x, input logic neg);
    cond_neg = neg ? (~x + 1'b1) : x;
  endfunction

  always_comb begin
    shifted = {rem_q, quo_q[N-1]};
    diff    = shifted - {1'b0, dvsr_q};
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    rem_d       = rem_q;
    quo_d       = quo_q;
    dvsr_d      = dvsr_q;
    dvnd_d      = dvnd_q;
    neg_quo_d   = neg_quo_q;
    neg_rem_d   = neg_rem_q;
    dz_d        = dz_q;
    quotient_d  = quotient_q;
    remainder_d = remainder_q;
    done_d      = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d   = CALC;
          cnt_d     = CW'(N - 1);
          rem_d     = '0;
          quo_d     = mag(dividend, is_signed);
          dvsr_d    = mag(divisor, is_signed);
          dvnd_d    = dividend;
          neg_quo_d = is_signed && (dividend[N-1] ^ divisor[N-1]);
          neg_rem_d = is_signed && dividend[N-1];
          dz_d      = (divisor == '0);
        end
      end
      CALC: begin
        // Negative trial difference means the divisor did not fit: restore.
        rem_d = diff[N] ? shifted[N-1:0] : diff[N-1:0];
        quo_d = {quo_q[N-2:0], ~diff[N]};
        cnt_d = cnt_q - 1'b1;
        if (cnt_q == '0) state_d = FIX;
      end
      FIX: begin
        state_d = IDLE;
        done_d  = 1'b1;
        if (dz_q) begin
          quotient_d  = '1;
          remainder_d = dvnd_q;
        end else begin
          quotient_d  = cond_neg(quo_q, neg_quo_q);
          remainder_d = cond_neg(rem_q, neg_rem_q);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      rem_q       <= '0;
      quo_q       <= '0;
      dvsr_q      <= '0;
      dvnd_q      <= '0;
      neg_quo_q   <= 1'b0;
      neg_rem_q   <= 1'b0;
      dz_q        <= 1'b0;
      quotient_q  <= '0;
      remainder_q <= '0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      rem_q       <= rem_d;
      quo_q       <= quo_d;
      dvsr_q      <= dvsr_d;
      dvnd_q      <= dvnd_d;
      neg_quo_q   <= neg_quo_d;
      neg_rem_q   <= neg_rem_d;
      dz_q        <= dz_d;
      quotient_q  <= quotient_d;
      remainder_q <= remainder_d;
      done_q      <= done_d;
    end
  end

  assign busy      = (state_q != IDLE);
  assign done      = done_q;
  assign quotient  = quotient_q;
  assign remainder = remainder_q;

endmodule

// File: tb/tb_seq_divider.sv
// Directed bench for seq_divider (N=32): result values, fixed latency, handshake and reset abort.
module tb_seq_divider;

  localparam int N = 32;
  localparam int LAT = N + 1;      // edges from accept edge to the done cycle
  localparam int TIMEOUT = 200;

  logic         clk = 1'b0;
  logic         reset;
  logic         start;
  logic         is_signed;
  logic [N-1:0] dividend;
  logic [N-1:0] divisor;
  logic         busy;
  logic         done;
  logic [N-1:0] quotient;
  logic [N-1:0] remainder;

  int total = 0;
  int bad   = 0;

  seq_divider #(.N(N)) dut (
    .clk(clk), .reset(reset), .start(start), .is_signed(is_signed),
    .dividend(dividend), .divisor(divisor), .busy(busy), .done(done),
    .quotient(quotient), .remainder(remainder)
  );

  always #5 clk = ~clk;

  // Drive a request now, let the next rising edge accept it, then drop start.
  task automatic launch(input logic sgn, input logic [N-1:0] a, input logic [N-1:0] b);
    start = 1'b1; is_signed = sgn; dividend = a; divisor = b;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  // Called one step after the accept edge; returns edges waited and busy cycles seen.
  task automatic wait_done(output int lat, output int busy_cnt, output int overlap);
    lat = 0; busy_cnt = 0; overlap = 0;
    while (!done && lat < TIMEOUT) begin
      if (busy) busy_cnt++;
      @(posedge clk); #1;
      lat++;
      if (done && busy) overlap++;
    end
  endtask

  task automatic check_op(input string name, input logic sgn, input logic [N-1:0] a,
                          input logic [N-1:0] b, input logic [N-1:0] eq, input logic [N-1:0] er);
    int lat, bc, ov;
    @(negedge clk);
    launch(sgn, a, b);
    wait_done(lat, bc, ov);
    total++;
    if (lat !== LAT) begin bad++; $display("FAIL %s latency got=%0d exp=%0d", name, lat, LAT); end
    total++;
    if (quotient !== eq) begin bad++; $display("FAIL %s quotient got=%h exp=%h", name, quotient, eq); end
    total++;
    if (remainder !== er) begin bad++; $display("FAIL %s remainder got=%h exp=%h", name, remainder, er); end
    total++;
    if (ov !== 0) begin bad++; $display("FAIL %s done_with_busy got=%0d exp=0", name, ov); end
  endtask

  task automatic test_reset;
    reset = 1'b1; start = 1'b0; is_signed = 1'b0; dividend = '0; divisor = '0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    total++;
    if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b exp=0", busy); end
    total++;
    if (done !== 1'b0) begin bad++; $display("FAIL reset_done got=%b exp=0", done); end
    total++;
    if (quotient !== '0) begin bad++; $display("FAIL reset_quotient got=%h exp=0", quotient); end
    total++;
    if (remainder !== '0) begin bad++; $display("FAIL reset_remainder got=%h exp=0", remainder); end
  endtask

  task automatic test_unsigned_basic;
    int lat, bc, ov;
    @(negedge clk);
    launch(1'b0, 32'd100, 32'd7);
    wait_done(lat, bc, ov);
    total++;
    if (lat !== LAT) begin bad++; $display("FAIL divu_latency got=%0d exp=%0d", lat, LAT); end
    total++;
    if (bc !== 33) begin bad++; $display("FAIL divu_busy_cycles got=%0d exp=33", bc); end
    total++;
    if (quotient !== 32'd14) begin bad++; $display("FAIL divu_quotient got=%h exp=%h", quotient, 32'd14); end
    total++;
    if (remainder !== 32'd2) begin bad++; $display("FAIL divu_remainder got=%h exp=%h", remainder, 32'd2); end
    @(posedge clk); #1;
    total++;
    if (done !== 1'b0) begin bad++; $display("FAIL done_pulse_width got=%b exp=0", done); end
    total++;
    if (quotient !== 32'd14) begin bad++; $display("FAIL quotient_hold got=%h exp=%h", quotient, 32'd14); end
    check_op("divu_max_by_3", 1'b0, 32'hFFFF_FFFF, 32'd3, 32'h5555_5555, 32'd0);
  endtask

  task automatic test_signs;
    check_op("div_m7_2",   1'b1, 32'hFFFF_FFF9, 32'd2,        32'hFFFF_FFFD, 32'hFFFF_FFFF);
    check_op("div_7_m2",   1'b1, 32'd7,         32'hFFFF_FFFE, 32'hFFFF_FFFD, 32'd1);
    check_op("div_m7_m2",  1'b1, 32'hFFFF_FFF9, 32'hFFFF_FFFE, 32'd3,        32'hFFFF_FFFF);
    check_op("div_m100_7", 1'b1, 32'hFFFF_FF9C, 32'd7,        32'hFFFF_FFF2, 32'hFFFF_FFFE);
  endtask

  task automatic test_div_zero;
    check_op("div_m5_0",  1'b1, 32'hFFFF_FFFB, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFB);
    check_op("divu_max_0", 1'b0, 32'hFFFF_FFFF, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    check_op("div_9_0",   1'b1, 32'd9,         32'd0, 32'hFFFF_FFFF, 32'd9);
  endtask

  task automatic test_overflow;
    check_op("div_min_m1",  1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32'd0);
    check_op("divu_min_m1", 1'b0, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0,         32'h8000_0000);
  endtask

  task automatic test_ignore_start;
    int lat, bc, ov;
    @(negedge clk);
    launch(1'b0, 32'd100, 32'd7);
    repeat (5) @(posedge clk);
    #1 start = 1'b1; dividend = 32'd50; divisor = 32'd5;
    @(posedge clk); #1 start = 1'b0;
    wait_done(lat, bc, ov);
    total++;
    if (lat !== LAT - 6) begin bad++; $display("FAIL ignore_latency got=%0d exp=%0d", lat, LAT - 6); end
    total++;
    if (quotient !== 32'd14) begin bad++; $display("FAIL ignore_quotient got=%h exp=%h", quotient, 32'd14); end
    total++;
    if (remainder !== 32'd2) begin bad++; $display("FAIL ignore_remainder got=%h exp=%h", remainder, 32'd2); end
    @(posedge clk); #1;
    total++;
    if (busy !== 1'b0) begin bad++; $display("FAIL ignore_no_restart got=%b exp=0", busy); end
  endtask

  task automatic test_back_to_back;
    int lat, bc, ov;
    @(negedge clk);
    launch(1'b0, 32'd1000, 32'd9);
    wait_done(lat, bc, ov);
    total++;
    if (quotient !== 32'd111) begin bad++; $display("FAIL b2b_first_quotient got=%h exp=%h", quotient, 32'd111); end
    launch(1'b1, 32'hFFFF_FC18, 32'd9);   // -1000 / 9, issued in the done cycle
    wait_done(lat, bc, ov);
    total++;
    if (lat !== LAT) begin bad++; $display("FAIL b2b_latency got=%0d exp=%0d", lat, LAT); end
    total++;
    if (quotient !== 32'hFFFF_FF91) begin bad++; $display("FAIL b2b_quotient got=%h exp=%h", quotient, 32'hFFFF_FF91); end
    total++;
    if (remainder !== 32'hFFFF_FFFF) begin bad++; $display("FAIL b2b_remainder got=%h exp=%h", remainder, 32'hFFFF_FFFF); end
  endtask

  task automatic test_reset_abort;
    int seen;
    @(negedge clk);
    launch(1'b0, 32'd77, 32'd5);
    repeat (9) @(posedge clk);
    #1 reset = 1'b1;
    @(posedge clk); #1 reset = 1'b0;
    total++;
    if (busy !== 1'b0) begin bad++; $display("FAIL abort_busy got=%b exp=0", busy); end
    total++;
    if (quotient !== '0) begin bad++; $display("FAIL abort_quotient got=%h exp=0", quotient); end
    total++;
    if (remainder !== '0) begin bad++; $display("FAIL abort_remainder got=%h exp=0", remainder); end
    seen = 0;
    for (int i = 0; i < 2 * LAT; i++) begin
      if (done || busy) seen++;
      @(posedge clk); #1;
    end
    total++;
    if (seen !== 0) begin bad++; $display("FAIL abort_no_done got=%0d exp=0", seen); end
  endtask

  initial begin
    test_reset;
    test_unsigned_basic;
    test_signs;
    test_div_zero;
    test_overflow;
    test_ignore_start;
    test_back_to_back;
    test_reset_abort;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
